// File: rtl/ahb_mem_slave_if.sv
// AHB-Lite signal bundle between a bus master (or interconnect) and ahb_mem_slave.
// The master modport drives the address/data phase; the slave modport returns the response.
interface ahb_mem_slave_if #(
    parameter int ADDR_W = 21,
    parameter int DATA_W = 32
);
    logic              HSEL;
    logic [ADDR_W-1:0] HADDR;
    logic [1:0]        HTRANS;
    logic              HWRITE;
    logic [2:0]        HSIZE;
    logic [DATA_W-1:0] HWDATA;
    logic              HREADY;
    logic              HREADYOUT;
    logic              HRESP;
    logic [DATA_W-1:0] HRDATA;

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
        input  HREADYOUT, HRESP, HRDATA
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
        output HREADYOUT, HRESP, HRDATA
    );
endinterface

// File: rtl/ahb_mem_slave.sv
// Parametrised AHB-Lite memory slave with byte-lane writes, programmable wait states and
// an optional two-cycle ERROR response, enabled by defining AHB_SLV_ERR_EN.
module ahb_mem_slave #(
    parameter int ADDR_W      = 21,
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 0
) (
    input logic            HCLK,
    input logic            HRESETn,
    ahb_mem_slave_if.slave bus
);

    localparam int BYTES  = DATA_W / 8;
    localparam int OFF_W  = $clog2(BYTES);
    localparam int LANE_W = (OFF_W > 0) ? OFF_W : 1;
    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [ADDR_W:0] MEM_BYTES = (ADDR_W + 1)'(DEPTH * BYTES);
    localparam logic [3:0]      WAIT_LAST = 4'(WAIT_CYCLES - 1);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] WAIT = 3'd1;
    localparam logic [2:0] DATA = 3'd2;
`ifdef AHB_SLV_ERR_EN
    localparam logic [2:0] ERR1 = 3'd3;
    localparam logic [2:0] ERR2 = 3'd4;
`endif

    if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : gWaitCheck
        $error("ahb_mem_slave: WAIT_CYCLES must be in 0..15");
    end
    if (DATA_W != 8 && DATA_W != 16 && DATA_W != 32 && DATA_W != 64) begin : gWidthCheck
        $error("ahb_mem_slave: DATA_W must be 8, 16, 32 or 64");
    end

    logic [2:0]        state_q, state_d;
    logic [3:0]        waitCnt_q, waitCnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              write_q, write_d;
    logic [2:0]        size_q, size_d;
    logic              bad_q, bad_d;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              accept;
    logic              badReq;
    logic [ADDR_W-1:0] alignMask;
    logic [LANE_W-1:0] lane;
    logic [IDX_W-1:0]  idx;
    logic [BYTES-1:0]  byteEn;
    logic              doWrite;
    logic              doRead;

    assign accept    = bus.HSEL && bus.HREADY && (bus.HTRANS == 2'b10 || bus.HTRANS == 2'b11);
    assign alignMask = (ADDR_W'(1) << bus.HSIZE) - ADDR_W'(1);
    assign badReq    = ({1'b0, bus.HADDR} >= MEM_BYTES) ||
                       (bus.HSIZE > 3'(OFF_W)) ||
                       ((bus.HADDR & alignMask) != '0);

    assign lane    = (OFF_W > 0) ? addr_q[LANE_W-1:0] : '0;
    assign idx     = IDX_W'(addr_q >> OFF_W);
    assign doWrite = (state_q == DATA) && write_q && !bad_q;
    assign doRead  = (state_q == DATA) && !write_q && !bad_q;

    // A transfer of 2^size bytes starting at the lane offset covers these byte lanes.
    always_comb begin
        byteEn = '0;
        for (int b = 0; b < BYTES; b++) begin
            if (b >= int'(lane) && b < int'(lane) + (1 << size_q)) begin
                byteEn[b] = 1'b1;
            end
        end
    end

    // IDLE, DATA and ERR2 all end a data phase, so each may accept the next address phase.
    always_comb begin
        state_d   = state_q;
        waitCnt_d = waitCnt_q;
        addr_d    = addr_q;
        write_d   = write_q;
        size_d    = size_q;
        bad_d     = bad_q;
        case (state_q)
            WAIT: begin
                if (waitCnt_q == WAIT_LAST) begin
                    state_d   = DATA;
                    waitCnt_d = '0;
                end else begin
                    waitCnt_d = waitCnt_q + 4'd1;
                end
            end
`ifdef AHB_SLV_ERR_EN
            ERR1: state_d = ERR2;
`endif
            default: begin
                state_d = IDLE;
                if (accept) begin
                    addr_d    = bus.HADDR;
                    write_d   = bus.HWRITE;
                    size_d    = bus.HSIZE;
                    bad_d     = badReq;
                    waitCnt_d = '0;
                    state_d   = (WAIT_CYCLES > 0) ? WAIT : DATA;
`ifdef AHB_SLV_ERR_EN
                    if (badReq) begin
                        state_d = ERR1;
                    end
`endif
                end
            end
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q   <= IDLE;
            waitCnt_q <= '0;
            addr_q    <= '0;
            write_q   <= 1'b0;
            size_q    <= '0;
            bad_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            waitCnt_q <= waitCnt_d;
            addr_q    <= addr_d;
            write_q   <= write_d;
            size_q    <= size_d;
            bad_q     <= bad_d;
        end
    end

    // Array is deliberately unreset; a reset forces IDLE so a pending write never commits.
    always_ff @(posedge HCLK) begin
        if (doWrite) begin
            for (int b = 0; b < BYTES; b++) begin
                if (byteEn[b]) begin
                    mem[idx][8*b +: 8] <= bus.HWDATA[8*b +: 8];
                end
            end
        end
    end

    assign bus.HRDATA = doRead ? mem[idx] : '0;
`ifdef AHB_SLV_ERR_EN
    assign bus.HREADYOUT = !((state_q == WAIT) || (state_q == ERR1));
    assign bus.HRESP     = (state_q == ERR1) || (state_q == ERR2);
`else
    assign bus.HREADYOUT = (state_q != WAIT);
    assign bus.HRESP     = 1'b0;
`endif

endmodule

// File: tb/tb_ahb_mem_slave.sv
// Scoreboard bench for ahb_mem_slave: one instance with one wait state, one with zero wait states.
// Expectations are queued at issue time and popped by per-instance monitors at each data-phase end.
`timescale 1ns/1ps
module tb_ahb_mem_slave;

`ifdef AHB_SLV_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    typedef struct {
        string       name;
        int          waits;
        logic        resp;
        logic        isRead;
        logic [31:0] rdata;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        hsel0, hsel1;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [20:0] haddr;
    logic [2:0]  hsize;
    logic [31:0] hwdata;

    int   tests = 0;
    int   fails = 0;
    exp_t q0[$];
    exp_t q1[$];

    logic act0 = 1'b0, act1 = 1'b0;
    int   lows0 = 0, lows1 = 0;
    logic lowResp0 = 1'b0, lowResp1 = 1'b0;

    always #5 clk = ~clk;

    ahb_mem_slave_if #(.ADDR_W(21), .DATA_W(32)) bus0();
    ahb_mem_slave_if #(.ADDR_W(21), .DATA_W(32)) bus1();

    assign bus0.HSEL   = hsel0;
    assign bus0.HADDR  = haddr;
    assign bus0.HTRANS = htrans;
    assign bus0.HWRITE = hwrite;
    assign bus0.HSIZE  = hsize;
    assign bus0.HWDATA = hwdata;
    assign bus0.HREADY = bus0.HREADYOUT;

    assign bus1.HSEL   = hsel1;
    assign bus1.HADDR  = haddr;
    assign bus1.HTRANS = htrans;
    assign bus1.HWRITE = hwrite;
    assign bus1.HSIZE  = hsize;
    assign bus1.HWDATA = hwdata;
    assign bus1.HREADY = bus1.HREADYOUT;

    ahb_mem_slave #(.ADDR_W(21), .DATA_W(32), .DEPTH(256), .WAIT_CYCLES(1)) dut0 (
        .HCLK    (clk),
        .HRESETn (rst_n),
        .bus     (bus0.slave)
    );

    ahb_mem_slave #(.ADDR_W(21), .DATA_W(32), .DEPTH(256), .WAIT_CYCLES(0)) dut1 (
        .HCLK    (clk),
        .HRESETn (rst_n),
        .bus     (bus1.slave)
    );

    task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic checkOutput(input int sel, input int lows, input logic lowResp,
                               input logic resp, input logic [31:0] rdata);
        exp_t e;
        if (sel == 0) begin
            if (q0.size() == 0) begin
                tests++; fails++;
                $display("[TB] FAIL dut0_unexpected_completion: got a data phase, expected none");
                return;
            end
            e = q0.pop_front();
        end else begin
            if (q1.size() == 0) begin
                tests++; fails++;
                $display("[TB] FAIL dut1_unexpected_completion: got a data phase, expected none");
                return;
            end
            e = q1.pop_front();
        end
        compare({e.name, "_waits"}, lows, e.waits);
        if (lows > 0) compare({e.name, "_hresp_low"}, 32'(lowResp), 32'(e.resp));
        compare({e.name, "_hresp"}, 32'(resp), 32'(e.resp));
        if (e.isRead) compare({e.name, "_hrdata"}, rdata, e.rdata);
    endtask

    // Monitors: count HREADYOUT=0 cycles of the active data phase, check at its last cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            act0 = 1'b0;
        end else begin
            if (act0) begin
                if (!bus0.HREADYOUT) begin
                    lows0++;
                    lowResp0 = lowResp0 | bus0.HRESP;
                end else begin
                    checkOutput(0, lows0, lowResp0, bus0.HRESP, bus0.HRDATA);
                    act0 = 1'b0;
                end
            end
            if (bus0.HSEL && bus0.HREADY && bus0.HTRANS[1]) begin
                act0 = 1'b1; lows0 = 0; lowResp0 = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            act1 = 1'b0;
        end else begin
            if (act1) begin
                if (!bus1.HREADYOUT) begin
                    lows1++;
                    lowResp1 = lowResp1 | bus1.HRESP;
                end else begin
                    checkOutput(1, lows1, lowResp1, bus1.HRESP, bus1.HRDATA);
                    act1 = 1'b0;
                end
            end
            if (bus1.HSEL && bus1.HREADY && bus1.HTRANS[1]) begin
                act1 = 1'b1; lows1 = 0; lowResp1 = 1'b0;
            end
        end
    end

    // Issue one NONSEQ address phase, queue its expectation, then drive its write data.
    task automatic applyStimulus(input string name, input int sel, input logic wr,
                                 input logic [20:0] addr, input logic [2:0] size,
                                 input logic [31:0] wdata, input logic bad,
                                 input logic [31:0] rdata);
        exp_t e;
        int   n;
        logic rdy;
        e.name   = name;
        e.isRead = !wr;
        e.rdata  = rdata;
        e.resp   = bad && ERR_EN;
        e.waits  = (bad && ERR_EN) ? 1 : ((sel == 0) ? 1 : 0);
        if (sel == 0) q0.push_back(e); else q1.push_back(e);
        hsel0  = (sel == 0);
        hsel1  = (sel == 1);
        htrans = 2'b10;
        hwrite = wr;
        haddr  = addr;
        hsize  = size;
        n = 0;
        do begin
            @(negedge clk);
            rdy = (sel == 0) ? bus0.HREADYOUT : bus1.HREADYOUT;
            @(posedge clk); #1;
            n++;
        end while (!rdy && n < 50);
        if (!rdy) begin
            tests++; fails++;
            $display("[TB] FAIL %s_accept_timeout: got no HREADY in %0d cycles, expected acceptance", name, n);
        end
        hwdata = wdata;
    endtask

    task automatic idleCycles(input int n);
        hsel0  = 1'b0;
        hsel1  = 1'b0;
        htrans = 2'b00;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int n;
        hsel0 = 1'b0; hsel1 = 1'b0; htrans = 2'b00; hwrite = 1'b0;
        haddr = '0; hsize = 3'd2; hwdata = '0;

        #12;
        compare("rst_dut0_hreadyout", 32'(bus0.HREADYOUT), 32'd1);
        compare("rst_dut0_hresp",     32'(bus0.HRESP),     32'd0);
        compare("rst_dut0_hrdata",    bus0.HRDATA,         32'd0);
        compare("rst_dut1_hreadyout", 32'(bus1.HREADYOUT), 32'd1);
        compare("rst_dut1_hresp",     32'(bus1.HRESP),     32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Word write then pipelined read-back with one wait state.
        applyStimulus("t1_wr", 0, 1'b1, 21'h010, 3'd2, 32'hDEADBEEF, 1'b0, 32'h0);
        applyStimulus("t1_rd", 0, 1'b0, 21'h010, 3'd2, 32'h0, 1'b0, 32'hDEADBEEF);

        // Byte and halfword lane writes.
        applyStimulus("t2_wr_byte13", 0, 1'b1, 21'h013, 3'd0, 32'hAA000000, 1'b0, 32'h0);
        applyStimulus("t2_rd10",      0, 1'b0, 21'h010, 3'd2, 32'h0, 1'b0, 32'hAAADBEEF);
        applyStimulus("t2_wr_word14", 0, 1'b1, 21'h014, 3'd2, 32'h11223344, 1'b0, 32'h0);
        applyStimulus("t2_wr_half14", 0, 1'b1, 21'h014, 3'd1, 32'h0000BEEF, 1'b0, 32'h0);
        applyStimulus("t2_rd14",      0, 1'b0, 21'h014, 3'd2, 32'h0, 1'b0, 32'h1122BEEF);

        // Last valid word, then bad transfers: out of range, unaligned, oversize, bad write.
        applyStimulus("t4_wr_last",  0, 1'b1, 21'h3FC, 3'd2, 32'hCAFEF00D, 1'b0, 32'h0);
        applyStimulus("t4_rd_last",  0, 1'b0, 21'h3FC, 3'd2, 32'h0, 1'b0, 32'hCAFEF00D);
        applyStimulus("t4_rd_oor",   0, 1'b0, 21'h400, 3'd2, 32'h0, 1'b1, 32'h0);
        applyStimulus("t4_rd_unal",  0, 1'b0, 21'h002, 3'd2, 32'h0, 1'b1, 32'h0);
        applyStimulus("t4_rd_size",  0, 1'b0, 21'h010, 3'd3, 32'h0, 1'b1, 32'h0);
        applyStimulus("t4_wr_unal",  0, 1'b1, 21'h012, 3'd2, 32'hFFFFFFFF, 1'b1, 32'h0);
        applyStimulus("t4_wr_oor",   0, 1'b1, 21'h400, 3'd2, 32'hFFFFFFFF, 1'b1, 32'h0);
        applyStimulus("t4_rd_after", 0, 1'b0, 21'h010, 3'd2, 32'h0, 1'b0, 32'hAAADBEEF);
        idleCycles(4);

        // IDLE and BUSY with HSEL=1, then NONSEQ with HSEL=0: no access, zero-wait OKAY.
        hsel0 = 1'b1; hwrite = 1'b1; haddr = 21'h010; hsize = 3'd2; hwdata = 32'h0;
        htrans = 2'b00;
        @(posedge clk); #1;
        htrans = 2'b01;
        @(negedge clk);
        compare("t5_idle_hreadyout", 32'(bus0.HREADYOUT), 32'd1);
        compare("t5_idle_hresp",     32'(bus0.HRESP),     32'd0);
        @(posedge clk); #1;
        hsel0 = 1'b0; htrans = 2'b10;
        @(negedge clk);
        compare("t5_busy_hreadyout", 32'(bus0.HREADYOUT), 32'd1);
        compare("t5_busy_hresp",     32'(bus0.HRESP),     32'd0);
        @(posedge clk); #1;
        htrans = 2'b00;
        @(negedge clk);
        compare("t5_nosel_hreadyout", 32'(bus0.HREADYOUT), 32'd1);
        @(posedge clk); #1;
        applyStimulus("t5_rd10", 0, 1'b0, 21'h010, 3'd2, 32'h0, 1'b0, 32'hAAADBEEF);
        idleCycles(4);

        // Zero-wait instance: back-to-back write/read, then a bad read.
        applyStimulus("t3_wr",     1, 1'b1, 21'h020, 3'd2, 32'h12345678, 1'b0, 32'h0);
        applyStimulus("t3_rd",     1, 1'b0, 21'h020, 3'd2, 32'h0, 1'b0, 32'h12345678);
        applyStimulus("t3_rd_oor", 1, 1'b0, 21'h400, 3'd2, 32'h0, 1'b1, 32'h0);
        idleCycles(4);

        // Reset during the wait state of a write discards that write.
        applyStimulus("t6_wr_prev", 0, 1'b1, 21'h030, 3'd2, 32'h0BADF00D, 1'b0, 32'h0);
        idleCycles(3);
        hsel0 = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = 21'h030; hsize = 3'd2;
        @(posedge clk); #1;
        hwdata = 32'h00000055;
        hsel0 = 1'b0; htrans = 2'b00;
        compare("t6_in_wait_hreadyout", 32'(bus0.HREADYOUT), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        compare("t6_rst_hreadyout", 32'(bus0.HREADYOUT), 32'd1);
        compare("t6_rst_hresp",     32'(bus0.HRESP),     32'd0);
        compare("t6_rst_hrdata",    bus0.HRDATA,         32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        applyStimulus("t6_rd", 0, 1'b0, 21'h030, 3'd2, 32'h0, 1'b0, 32'h0BADF00D);
        idleCycles(4);

        n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 50) begin
            @(posedge clk); n++;
        end
        if (q0.size() != 0 || q1.size() != 0) begin
            tests++; fails++;
            $display("[TB] FAIL drain: got %0d outstanding transfers, expected 0", q0.size() + q1.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
